// File: rtl/imem_if.sv
// Instruction-memory write port shared by the loader (master) and the memory (slave).
interface imem_if #(
  parameter int ADDR_W = 10
);
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;

  modport master (output we, output addr, output wdata);
  modport slave  (input  we, input  addr, input  wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// UART program loader: receives an A5/LEN/payload/CSUM frame and writes it word by word
// into instruction memory, holding the core in reset until a load checks out.
module imem_uart_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          uart_rx,
  imem_if.master        imem,
  output logic          core_rst,
  output logic          load_done,
  output logic          load_err,
  output logic [ADDR_W:0] word_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0]      CAPACITY = 17'(2 ** ADDR_W);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_LEN_LO, L_LEN_HI, L_DATA, L_CSUM, L_ERROR} ld_state_t;

  // ---------------- RX front end ----------------
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line already back high at mid-start was only a glitch.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          rx_valid_d = rx_sync_q;
          rx_ferr_d  = !rx_sync_q;
          rx_state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- Loader FSM ----------------
  ld_state_t         ld_state_q, ld_state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        xor_q, xor_d;
  logic [31:0]       asm_q, asm_d;
  logic [ADDR_W:0]   word_count_q, word_count_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              core_rst_q, core_rst_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   wc_inc;

  assign len_full = {shift_q, len_q[7:0]};
  assign wc_inc   = word_count_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_state_q   <= L_IDLE;
      len_q        <= '0;
      byte_idx_q   <= '0;
      xor_q        <= '0;
      asm_q        <= '0;
      word_count_q <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      ld_state_q   <= ld_state_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      xor_q        <= xor_d;
      asm_q        <= asm_d;
      word_count_q <= word_count_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_q   <= core_rst_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  always_comb begin
    ld_state_d   = ld_state_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    xor_d        = xor_q;
    asm_d        = asm_q;
    word_count_d = word_count_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_rst_d   = core_rst_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    case (ld_state_q)
      L_IDLE: begin
        if (rx_valid_q && shift_q == SYNC_BYTE) begin
          ld_state_d   = L_LEN_LO;
          core_rst_d   = 1'b1;
          load_done_d  = 1'b0;
          load_err_d   = 1'b0;
          word_count_d = '0;
          byte_idx_d   = '0;
          xor_d        = '0;
        end
      end
      L_LEN_LO: begin
        if (rx_valid_q) begin
          len_d      = {8'h00, shift_q};
          ld_state_d = L_LEN_HI;
        end
      end
      L_LEN_HI: begin
        if (rx_valid_q) begin
          len_d = len_full;
          if ({1'b0, len_full} > CAPACITY) ld_state_d = L_ERROR;
          else if (len_full == 16'd0)      ld_state_d = L_CSUM;
          else                             ld_state_d = L_DATA;
        end
      end
      L_DATA: begin
        if (rx_valid_q) begin
          asm_d[8*byte_idx_q +: 8] = shift_q;
          xor_d      = xor_q ^ shift_q;
          byte_idx_d = byte_idx_q + 1'b1;
          if (byte_idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count_q[ADDR_W-1:0];
            imem_wdata_d = {shift_q, asm_q[23:0]};
            word_count_d = wc_inc;
            if (16'(wc_inc) == len_q) ld_state_d = L_CSUM;
          end
        end
      end
      L_CSUM: begin
        if (rx_valid_q) begin
          if (shift_q == xor_q) begin
            load_done_d = 1'b1;
            core_rst_d  = 1'b0;
            ld_state_d  = L_IDLE;
          end else begin
            ld_state_d = L_ERROR;
          end
        end
      end
      L_ERROR: begin
        load_err_d = 1'b1;
        ld_state_d = L_IDLE;
      end
      default: ld_state_d = L_IDLE;
    endcase
    // A framing error aborts any load in flight; in IDLE it is just line noise.
    if (rx_ferr_q && ld_state_q != L_IDLE && ld_state_q != L_ERROR) ld_state_d = L_ERROR;
  end

  assign imem.we    = imem_we_q;
  assign imem.addr  = imem_addr_q;
  assign imem.wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: good load, bad checksum, length overflow,
// framing error, start glitch and reset mid-load.
module tb_imem_uart_loader;
  localparam int C  = 8;
  localparam int AW = 4;
  localparam logic [87:0] GOOD_HDR_PAYLOAD = 88'hA5_02_00_93_00_50_00_13_01_30_00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic core_rst, load_done, load_err;
  logic [AW:0] word_count;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  logic [31:0] wr_addr [0:3];
  logic [31:0] wr_data [0:3];

  imem_if #(.ADDR_W(AW)) imem_bus ();

  imem_uart_loader #(.CLKS_PER_BIT(C), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .imem(imem_bus),
    .core_rst(core_rst), .load_done(load_done), .load_err(load_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_bus.we === 1'b1) begin
      if (wr_cnt < 4) begin
        wr_addr[wr_cnt] = 32'(imem_bus.addr);
        wr_data[wr_cnt] = imem_bus.wdata;
      end
      $display("write #%0d addr=%0d data=0x%08h", wr_cnt, imem_bus.addr, imem_bus.wdata);
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (C) @(negedge clk);
    end
    uart_rx = stop;
    repeat (C) @(negedge clk);
    uart_rx = 1'b1;
    $display("sent byte 0x%02h stop=%0b", b, stop);
  endtask

  // Sends A5 02 00 + 8 payload bytes, then the given checksum byte.
  task automatic send_frame(input logic [7:0] csum);
    logic [87:0] fr;
    fr = GOOD_HDR_PAYLOAD;
    for (int i = 0; i < 11; i++) send_byte(fr[87-8*i -: 8], 1'b1);
    send_byte(csum, 1'b1);
    repeat (2 * C) @(negedge clk);
  endtask

  task automatic check_good(input string p);
    check({p, "_wr_cnt"}, 32'(wr_cnt), 32'd2);
    check({p, "_addr0"}, wr_addr[0], 32'd0);
    check({p, "_data0"}, wr_data[0], 32'h00500093);
    check({p, "_addr1"}, wr_addr[1], 32'd1);
    check({p, "_data1"}, wr_data[1], 32'h00300113);
    check({p, "_wc"}, 32'(word_count), 32'd2);
    check({p, "_done"}, 32'(load_done), 32'd1);
    check({p, "_err"}, 32'(load_err), 32'd0);
    check({p, "_core_rst"}, 32'(core_rst), 32'd0);
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_we"}, 32'(imem_bus.we), 32'd0);
    check({p, "_addr"}, 32'(imem_bus.addr), 32'd0);
    check({p, "_wdata"}, imem_bus.wdata, 32'd0);
    check({p, "_core_rst"}, 32'(core_rst), 32'd0);
    check({p, "_done"}, 32'(load_done), 32'd0);
    check({p, "_err"}, 32'(load_err), 32'd0);
    check({p, "_wc"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    logic [87:0] fr;
    // Reset
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Good load with leading noise bytes
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    check("noise_core_rst", 32'(core_rst), 32'd0);
    check("noise_wr_cnt", 32'(wr_cnt), 32'd0);
    fr = GOOD_HDR_PAYLOAD;
    send_byte(8'hA5, 1'b1);
    check("sync_core_rst", 32'(core_rst), 32'd1);
    for (int i = 1; i < 11; i++) send_byte(fr[87-8*i -: 8], 1'b1);
    check("pre_csum_core_rst", 32'(core_rst), 32'd1);
    check("pre_csum_done", 32'(load_done), 32'd0);
    send_byte(8'hE1, 1'b1);
    repeat (2 * C) @(negedge clk);
    check_good("good");

    // Bad checksum, then recovery
    wr_cnt = 0;
    send_frame(8'hE0);
    check("badcs_wr_cnt", 32'(wr_cnt), 32'd2);
    check("badcs_err", 32'(load_err), 32'd1);
    check("badcs_done", 32'(load_done), 32'd0);
    check("badcs_core_rst", 32'(core_rst), 32'd1);
    wr_cnt = 0;
    send_frame(8'hE1);
    check_good("recover");

    // Length overflow: 17 words > 16-word memory
    wr_cnt = 0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (2 * C) @(negedge clk);
    check("ovf_wr_cnt", 32'(wr_cnt), 32'd0);
    check("ovf_err", 32'(load_err), 32'd1);
    check("ovf_core_rst", 32'(core_rst), 32'd1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (2 * C) @(negedge clk);
    check("zero_done", 32'(load_done), 32'd1);
    check("zero_wc", 32'(word_count), 32'd0);
    check("zero_err", 32'(load_err), 32'd0);
    check("zero_core_rst", 32'(core_rst), 32'd0);

    // Framing error mid-payload
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (2 * C) @(negedge clk);
    check("ferr_err", 32'(load_err), 32'd1);
    check("ferr_wr_cnt", 32'(wr_cnt), 32'd0);
    check("ferr_core_rst", 32'(core_rst), 32'd1);

    // Start-bit glitch in IDLE: nothing may change
    uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * C) @(negedge clk);
    $display("glitch applied");
    check("glitch_wr_cnt", 32'(wr_cnt), 32'd0);
    check("glitch_err", 32'(load_err), 32'd1);
    check("glitch_core_rst", 32'(core_rst), 32'd1);
    check("glitch_wc", 32'(word_count), 32'd0);
    check("glitch_addr", 32'(imem_bus.addr), 32'd1);
    check("glitch_wdata", imem_bus.wdata, 32'h00300113);
    send_frame(8'hE1);
    check_good("post_glitch");

    // Reset after the 5th payload byte
    wr_cnt = 0;
    for (int i = 0; i < 8; i++) send_byte(fr[87-8*i -: 8], 1'b1);
    check("midload_core_rst", 32'(core_rst), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_low");
    repeat (3) @(negedge clk);
    check_reset_vals("rst_low_end");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    wr_cnt = 0;
    send_frame(8'hE1);
    check_good("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

Board-level program loader for the RISC-V core. It receives a framed program image over a UART RX line and writes it, one 32-bit word at a time, into the instruction memory write port. It holds the core in reset for the duration of a load. It is the hardware counterpart of backdoor instruction loading: it fills `instr_mem` from outside the core instead of from simulation.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 4.
- `ADDR_W`, default 10: instruction memory word-address width. Capacity is 2^ADDR_W words.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `uart_rx`, input, 1: serial input, 8N1, LSB first, idles high. Asynchronous to `clk`.
- `imem_we`, output, 1: instruction memory write strobe, one cycle per word.
- `imem_addr`, output, ADDR_W: word address of the write.
- `imem_wdata`, output, 32: instruction word to write.
- `core_rst`, output, 1: active-high reset to the core, asserted while a load is in progress or has failed.
- `load_done`, output, 1: sticky; the last load completed with a good checksum.
- `load_err`, output, 1: sticky; the last load failed.
- `word_count`, output, ADDR_W+1: number of words written in the current or last load.

## Operation
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_rst`=0, `load_done`=0, `load_err`=0, `word_count`=0. The synchronizer flops and the RX line state reset to 1. Out of reset the core runs whatever image the memory already holds.
- RX front end:
  - `uart_rx` passes through a 2-flop synchronizer.
  - A falling edge starts a bit timer. At CLKS_PER_BIT/2 the line is re-sampled; if it is high, the start is treated as a glitch and dropped.
  - The 8 data bits are sampled every CLKS_PER_BIT cycles, then the stop bit.
  - Stop bit = 1: a 1-cycle `rx_valid` pulse is issued with `rx_byte`.
  - Stop bit = 0: a 1-cycle `rx_ferr` pulse is issued and no byte is delivered.
  - The RX returns to idle after the stop-bit sample.
- Frame format: sync 0xA5, then LEN_LO, then LEN_HI (16-bit word count N), then 4·N payload bytes (each word little-endian), then CSUM. CSUM is the XOR of all payload bytes.
- Loader FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, ERROR.
  - IDLE: any byte other than 0xA5 is ignored. On 0xA5: go to LEN_LO; set `core_rst`=1; clear `load_done`, `load_err`, `word_count`, the byte index and the running XOR.
  - LEN_LO / LEN_HI: capture N. If N > 2^ADDR_W, go to ERROR. If N = 0, go to CSUM. Otherwise go to DATA.
  - DATA: bytes are shifted into a 32-bit assembly register in byte lanes [7:0], [15:8], [23:16], [31:24], and each byte is XORed into the running checksum. On the 4th byte: drive `imem_we` for one cycle with `imem_addr`=`word_count`[ADDR_W-1:0] and `imem_wdata`=the assembled word, then increment `word_count`. After word N, go to CSUM.
  - CSUM: if the byte equals the running XOR, set `load_done`=1, clear `core_rst`, and go to IDLE. Otherwise go to ERROR.
  - ERROR: set `load_err`=1 and go to IDLE. `core_rst` stays 1 until a later load succeeds.
- An `rx_ferr` in any state other than IDLE goes to ERROR. An `rx_ferr` in IDLE is ignored.
- Words already written before a failure are not rolled back. The core stays in reset, so they are never executed.
- A 0xA5 received in DATA is payload, not a resync.
- `imem_addr` and `imem_wdata` hold their last values when `imem_we`=0.
- Reset mid-load: every register returns to its reset value immediately, including `core_rst`=0. A partial image may then be executed; the system integrator must hold `rst_n` low until a new load starts.

## Timing
- The stop bit is sampled at mid-bit. `rx_valid` goes high the next cycle.
- The FSM updates on the cycle `rx_valid` is high.
- `imem_we` is high exactly one cycle, the cycle after the `rx_valid` of the 4th byte of a word.
- `load_done` and the `core_rst` falling edge occur the cycle after the `rx_valid` of CSUM. `load_err` rises 2 cycles after the offending `rx_valid`/`rx_ferr` (ERROR takes one state cycle).
- `core_rst` rises the cycle after the `rx_valid` of 0xA5.
- Back-to-back bytes with zero idle time between stop and start bits are fully supported. Minimum byte spacing is 10·CLKS_PER_BIT cycles.
- Only `rst_n` is asynchronous; every other output is registered.

## Test plan
Bench parameters: CLKS_PER_BIT=8, ADDR_W=4.
- **Good load.** Send 00 FF A5 02 00 93 00 50 00 13 01 30 00 E1. Required: two `imem_we` pulses, addr0=0x00500093 then addr1=0x00300113; `word_count`=2; `load_done`=1; `load_err`=0; `core_rst` rises after A5 and falls after E1.
- **Bad checksum.** Same frame with CSUM=E0. Required: two writes, `load_err`=1, `load_done`=0, `core_rst` stays 1. Then resend the good frame: `load_done`=1, `core_rst`=0.
- **Length overflow.** Send A5 11 00. Required: no `imem_we`, `load_err`=1. Then A5 00 00 00: `load_done`=1, `word_count`=0.
- **Framing error mid-payload.** Send A5 01 00 93 followed by a byte with stop bit = 0. Required: `load_err`=1, no `imem_we`.
- **Start-bit glitch.** A 2-cycle low pulse on `uart_rx` in IDLE. Required: no `rx_valid`, all outputs unchanged. Then the good frame loads correctly.
- **Reset mid-load.** Pull `rst_n` low for 3 cycles after the 5th payload byte. Required: all outputs at reset values while low. Then the good frame loads correctly with `word_count`=2.
